hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter: NUM_SRC, default 6, number of ID-stage source ports checked (src1..src4, store_src, store_src2).
REQ-002 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
REQ-004 Source and destination ports SHALL be:
- src1_ID, src2_ID, src3_ID, src4_ID, store_src_ID, store_src2_ID  in  4 each  register sources of the instruction in ID.
- write_reg_EXE, write_reg2_EXE  in  4 each  destinations of the instruction in EXE.
REQ-005 Control inputs SHALL be:
- reg_write_en_EXE  in  1  EXE instruction writes registers.
- mem_read_EXE  in  1  EXE instruction is a load.
- dual_load_EXE  in  1  load-pair; write_reg2 data arrives one cycle after write_reg data.
- mem_busy  in  1  data memory wait; freezes the whole pipeline.
- branch_taken_EXE  in  1  branch resolved taken in EXE.
- clear_stats  in  1  clears the stall counter.
REQ-006 Outputs SHALL be:
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_bubble  out  1  load a NOP into ID/EXE.
- if_id_flush  out  1  flush IF/ID.
- id_ex_flush  out  1  flush ID/EXE.
- mem_stall  out  1  freeze EXE/MEM and MEM/WB.
- hazard_state  out  2  current FSM state.
- stall_cycles  out  CNT_W  bubble-cycle counter.

Function
REQ-007 A source SHALL match a destination only if the source is nonzero, the two register numbers are equal, and reg_write_en_EXE=1; register 0 SHALL never match.
REQ-008 Hazard conditions SHALL be:
- hz1 = mem_read_EXE AND any source matches write_reg_EXE.
- hz2 = mem_read_EXE AND dual_load_EXE AND any source matches write_reg2_EXE.
REQ-009 The FSM SHALL have two states: HZ_IDLE (2'b00) and HZ_HOLD (2'b01). hazard_state SHALL equal the registered state.
REQ-010 Output priority per cycle SHALL be mem_busy > branch_taken_EXE > HZ_HOLD > hz1/hz2 > normal.
REQ-011 When mem_busy=1:
- mem_stall=1, pc_en=0, if_id_en=0, id_ex_bubble=0, both flushes 0.
- FSM state and counter SHALL hold.
REQ-012 When mem_busy=0 and branch_taken_EXE=1:
- if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1, id_ex_bubble=0.
- Next state SHALL be HZ_IDLE, cancelling any pending HOLD.
REQ-013 In HZ_IDLE with hz1 or hz2 (no mem_busy, no branch):
- pc_en=0, if_id_en=0, id_ex_bubble=1.
- Next state SHALL be HZ_HOLD if hz2, else HZ_IDLE.
REQ-014 In HZ_HOLD (no mem_busy, no branch):
- pc_en=0, if_id_en=0, id_ex_bubble=1.
- Next state SHALL be HZ_IDLE, giving exactly two bubbles for a load-pair second-register use.
REQ-015 Otherwise (normal): pc_en=1, if_id_en=1, all other control outputs 0.
REQ-016 All control outputs SHALL be combinational from the state and inputs (zero latency); the state SHALL update on the rising edge of clk.
REQ-017 stall_cycles SHALL increment by 1 on each edge where id_ex_bubble=1, saturating at all-ones without wrapping.
REQ-018 clear_stats=1 SHALL zero stall_cycles on the next edge; clear SHALL take priority over increment.

Reset
REQ-019 With rst_n=0 at an edge: state SHALL become HZ_IDLE and stall_cycles 0.
REQ-020 While rst_n=0, outputs SHALL be:
- pc_en=0, if_id_en=0, id_ex_bubble=1.
- both flushes 0, mem_stall=0.
REQ-021 Reset asserted during HZ_HOLD SHALL abandon the hold; the first cycle after reset SHALL be evaluated in HZ_IDLE.

Structure
REQ-022 Shared package pipeline_pkg SHALL hold:
- REG_ZERO (4'b0000) and the register-index width.
- hazard_state_t enum (HZ_IDLE, HZ_HOLD).
REQ-023 One sub-module, hazard_src_match, SHALL compare NUM_SRC sources against one destination and return a match bit; it SHALL be instantiated twice (write_reg_EXE, write_reg2_EXE).

Verification
REQ-024 Scenario 1, load-use:
- Stimulus: mem_read_EXE=1, write_reg_EXE=5, src2_ID=5.
- Response: one cycle with pc_en=0 and id_ex_bubble=1; stall_cycles=1.
REQ-025 Scenario 2, load-pair second register:
- Stimulus: dual_load_EXE=1, write_reg2_EXE=7, store_src2_ID=7.
- Response: two bubble cycles, hazard_state 00->01->00; stall_cycles=2.
REQ-026 Scenario 3, register zero:
- Stimulus: load writing reg 0, src1_ID=0.
- Response: no stall; pc_en=1.
REQ-027 Scenario 4, memory wait during hold:
- Stimulus: mem_busy=1 for 3 cycles while in HZ_HOLD.
- Response: mem_stall=1 and bubble=0 during the wait; state remains 01; one bubble after release.
REQ-028 Scenario 5, branch cancels hold:
- Stimulus: branch_taken_EXE=1 while in HZ_HOLD.
- Response: both flushes=1, pc_en=1, next state 00.
REQ-029 Scenario 6, counter saturation and reset:
- Stimulus: preload stall_cycles to 16'hFFFF, then bubble; then clear_stats=1 with bubble; then rst_n=0 mid-HOLD.
- Response: value stays 16'hFFFF; clear gives 0; reset gives state 00 and bubble=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
// Holds the register-index width, the hardwired-zero register number and
// the hazard FSM state encoding used by the stall unit and its comparators.
package pipeline_pkg;

    localparam int unsigned REG_W = 4;
    localparam logic [REG_W-1:0] REG_ZERO = 4'b0000;

    typedef enum logic [1:0] {
        HZ_IDLE = 2'b00,
        HZ_HOLD = 2'b01
    } hazard_state_t;

endpackage

// File: rtl/hazard_src_match.sv
// Source/destination comparator.
// Compares NUM_SRC ID-stage source register numbers against one EXE-stage
// destination and reports whether any of them depends on it.
// Ports:
//   src_i    NUM_SRC packed register numbers
//   dst_i    destination register number
//   wr_en_i  destination is actually written
//   match_o  at least one nonzero source equals the destination
module hazard_src_match
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_SRC = 6
) (
    input  logic [NUM_SRC-1:0][REG_W-1:0] src_i,
    input  logic [REG_W-1:0]              dst_i,
    input  logic                          wr_en_i,
    output logic                          match_o
);

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Register zero is hardwired and never carries a dependency.
            if (wr_en_i && (src_i[i] != REG_ZERO) && (src_i[i] == dst_i)) begin
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard and stall controller.
// Detects load-use hazards against the EXE-stage load (including the late
// second register of a load-pair), freezes the pipeline on a memory wait,
// flushes on a taken branch and counts bubble cycles.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   src*_ID, store_src*_ID        ID-stage source registers
//   write_reg_EXE, write_reg2_EXE EXE-stage destinations
//   reg_write_en_EXE, mem_read_EXE, dual_load_EXE, mem_busy,
//   branch_taken_EXE, clear_stats control inputs
//   pc_en, if_id_en, id_ex_bubble, if_id_flush, id_ex_flush, mem_stall
//                                 combinational pipeline controls
//   hazard_state                  registered FSM state
//   stall_cycles                  saturating bubble-cycle counter
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic [REG_W-1:0] src3_ID,
    input  logic [REG_W-1:0] src4_ID,
    input  logic [REG_W-1:0] store_src_ID,
    input  logic [REG_W-1:0] store_src2_ID,
    input  logic [REG_W-1:0] write_reg_EXE,
    input  logic [REG_W-1:0] write_reg2_EXE,
    input  logic             reg_write_en_EXE,
    input  logic             mem_read_EXE,
    input  logic             dual_load_EXE,
    input  logic             mem_busy,
    input  logic             branch_taken_EXE,
    input  logic             clear_stats,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_stall,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned NUM_PORTS = 6;

    hazard_state_t    state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [NUM_PORTS-1:0][REG_W-1:0] port_src;
    logic [NUM_SRC-1:0][REG_W-1:0]   src_vec;
    logic                            match1, match2;
    logic                            hz1, hz2;

    assign port_src = {store_src2_ID, store_src_ID, src4_ID, src3_ID, src2_ID, src1_ID};

    // Sources beyond the physical ports read as register zero (never match).
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        if (g < NUM_PORTS) begin : g_port
            assign src_vec[g] = port_src[g];
        end else begin : g_zero
            assign src_vec[g] = REG_ZERO;
        end
    end

    hazard_src_match #(
        .NUM_SRC (NUM_SRC)
    ) u_match1 (
        .src_i   (src_vec),
        .dst_i   (write_reg_EXE),
        .wr_en_i (reg_write_en_EXE),
        .match_o (match1)
    );

    hazard_src_match #(
        .NUM_SRC (NUM_SRC)
    ) u_match2 (
        .src_i   (src_vec),
        .dst_i   (write_reg2_EXE),
        .wr_en_i (reg_write_en_EXE),
        .match_o (match2)
    );

    assign hz1 = mem_read_EXE & match1;
    // The second load-pair register lands a cycle late, hence the extra hold.
    assign hz2 = mem_read_EXE & dual_load_EXE & match2;

    // Pipeline controls and next state, in priority order.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_stall    = 1'b0;
        state_d      = state_q;

        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = HZ_IDLE;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            mem_stall = 1'b1;
        end else if (branch_taken_EXE) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = HZ_IDLE;
        end else if (state_q == HZ_HOLD) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = HZ_IDLE;
        end else if (hz1 || hz2) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = hz2 ? HZ_HOLD : HZ_IDLE;
        end else begin
            state_d = HZ_IDLE;
        end
    end

    // Saturating bubble counter; a memory wait freezes it along with the FSM.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!mem_busy) begin
            if (clear_stats) begin
                stall_cycles_d = '0;
            end else if (id_ex_bubble && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= HZ_IDLE;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hazard_state = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule
